risc_v_cpu: RTL and testbench
=============================

// Module: risc_v_cpu
// PURPOSE
// - Single-cycle RV32I processor core with private instruction and data memories; top of the CPU design.
// - Retires exactly one instruction per rising clock edge.
// - Benches preload the program by hierarchical write into instruction memory, then probe PC, registers and data memory.
// PARAMETERS
// - IMEM_BYTES  1024  instruction memory size in bytes (byte array)
// - DMEM_BYTES  1024  data memory size in bytes (byte array)
// PORTS
// - clock  in   1   single clock; all state updates on rising edge
// - reset  in   1   asynchronous, active-low reset
// - out    out  32  write-back value of the instruction executing this cycle (0 if no rd write)
// BEHAVIOUR
// - Reset asserted (reset==0), async:
//   - PC=0; all 32 registers=0; out=0.
//   - Memory contents are NOT cleared, so a preloaded program survives reset.
// - Fetch:
//   - instr = {imem[pc+3], imem[pc+2], imem[pc+1], imem[pc]} (little-endian).
//   - Addresses wrap modulo IMEM_BYTES.
// - ISA: full RV32I — LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU, LB/LH/LW/LBU/LHU, SB/SH/SW, all OP-IMM and OP.
//   - FENCE, ECALL, EBREAK, CSR and unknown opcodes execute as NOP (PC+4, no writes).
// - Per rising edge, in one cycle:
//   - PC <= next_pc.
//   - Register rd <= wb if the instruction writes rd and rd!=0.
//   - Store bytes are written.
// - x0 always reads 0; writes to it are discarded.
// - next_pc:
//   - JAL: pc+imm_j.
//   - JALR: (rs1+imm_i) & ~1.
//   - Taken branch: pc+imm_b.
//   - Otherwise: pc+4.
//   - All arithmetic is 32-bit, wrapping.
// - Link value for JAL/JALR: pc+4. AUIPC: pc+imm_u. LUI: imm_u.
// - Shifts use the low 5 bits of the shift operand; SRA/SRAI are arithmetic.
// - SLT/SLTI compare signed; SLTU/SLTIU compare unsigned (SLTIU sign-extends the immediate first).
// - Data memory:
//   - Byte-addressed, little-endian, address wraps modulo DMEM_BYTES.
//   - Misaligned halfword/word access is performed bytewise (no trap).
//   - Loads are combinational; LB/LH sign-extend, LBU/LHU zero-extend.
//   - Stores write 1, 2 or 4 bytes on the clock edge.
// - Register file: 2 combinational read ports, 1 synchronous write port. Reads in the same cycle as a write see the old value.
// - out is combinational wb data (ALU result, load data, link value or U-immediate).
// STRUCTURE
// - Shared package rv32i_pkg:
//   - opcode constants;
//   - funct3 codes;
//   - alu_op_t enum (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASS_B);
//   - imm_sel_t enum (I, S, B, U, J).
// - Required instance names and internal signals, because benches probe them hierarchically:
//   - program_counter (reg [31:0] pc_addr)
//   - registers_bank (reg [31:0] registers[0:31])
//   - uut_instruction (reg [7:0] memory[0:IMEM_BYTES-1])
//   - memory (reg [7:0] memory[0:DMEM_BYTES-1]) for data
// - Decoder, immediate generator and ALU stay inline in risc_v_cpu. The register bank is the natural standalone sub-module: registers_bank.
// TESTING
// - Reset:
//   - stimulus: preload program, hold reset low, release;
//   - response: pc_addr==0 and registers all 0 before the first edge.
// - Arithmetic:
//   - stimulus: addi x1,x0,5; addi x2,x0,-3; add x3,x1,x2; sub x4,x2,x1; slt x5,x2,x1; sltu x6,x2,x1; srai x7,x2,1;
//   - response: x1=5, x2=0xFFFFFFFD, x3=2, x4=0xFFFFFFF8, x5=1, x6=0, x7=0xFFFFFFFE, each checked one edge after issue.
// - Upper immediates and x0:
//   - stimulus: lui x1,0x12345; auipc x2,1 at pc 4; addi x0,x0,7;
//   - response: x1=0x12345000, x2=0x1004, x0=0.
// - Branch and jump:
//   - stimulus: beq x0,x0,+8 at pc 0; then jal x1,+12 at pc 8; jalr x2,x1,1 at pc 20;
//   - response: after each edge pc_addr=8, then 20 with x1=12, then 12 with x2=24.
//   - stimulus: an untaken bne;
//   - response: pc_addr advances by 4.
// - Load/store:
//   - stimulus: addi x1,x0,-1; sw x1,8(x0); sb x0,9(x0); lw x2,8(x0); lbu x3,8(x0); lh x4,8(x0);
//   - response: x2=0xFFFF00FF, x3=0xFF, x4=0x000000FF; data memory[8..11]=FF,00,FF,FF.
// - Async reset mid-run:
//   - stimulus: pull reset low between edges after 3 instructions;
//   - response: pc_addr and registers return to 0 immediately; data memory unchanged.

Source files
------------

// File: rtl/risc_v_cpu_pkg.sv
// RV32I encodings, control enums and decode helpers shared by the single-cycle core.
package rv32i_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  localparam logic [2:0] F3_SB = 3'd0;
  localparam logic [2:0] F3_SH = 3'd1;
  localparam logic [2:0] F3_SW = 3'd2;

  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
  } alu_op_t;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_sel_t;

  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_LINK} wb_sel_t;

  function automatic logic [31:0] gen_imm(input logic [31:0] instr, input imm_sel_t sel);
    logic [31:0] imm;
    case (sel)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'h000};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = 32'h0000_0000;
    endcase
    return imm;
  endfunction

  // alt selects SUB for funct3 0 and SRA for funct3 5 (instr bit 30).
  function automatic alu_op_t alu_from_f3(input logic [2:0] f3, input logic alt);
    alu_op_t op;
    case (f3)
      F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  op = ALU_SLL;
      F3_SLT:  op = ALU_SLT;
      F3_SLTU: op = ALU_SLTU;
      F3_XOR:  op = ALU_XOR;
      F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   op = ALU_OR;
      F3_AND:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/risc_v_cpu_mem.sv
// Program counter register plus byte-array instruction and data memories.
// Memories have no reset so a preloaded program and stored data survive it.
module pc_register (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] next_pc,
  output logic [31:0] pc_addr
);

  // Program counter, cleared asynchronously.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_addr <= 32'h0000_0000;
    end else begin
      pc_addr <= next_pc;
    end
  end

endmodule

module instr_memory #(
  parameter int IMEM_BYTES = 1024
) (
  input  logic [31:0] addr,
  output logic [31:0] rdata
);

  localparam int AW = $clog2(IMEM_BYTES);

  logic [7:0] memory [0:IMEM_BYTES-1];

  function automatic logic [AW-1:0] byte_idx(input logic [31:0] a, input int k);
    return AW'((a + 32'(k)) % 32'(IMEM_BYTES));
  endfunction

  // Little-endian fetch, each byte address wrapping independently.
  always_comb begin
    rdata = 32'h0000_0000;
    for (int k = 0; k < 4; k++) begin
      rdata[8*k +: 8] = memory[byte_idx(addr, k)];
    end
  end

endmodule

module data_memory #(
  parameter int DMEM_BYTES = 1024
) (
  input  logic        clock,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic [31:0] rdata
);

  localparam int AW = $clog2(DMEM_BYTES);

  logic [7:0] memory [0:DMEM_BYTES-1];

  function automatic logic [AW-1:0] byte_idx(input logic [31:0] a, input int k);
    return AW'((a + 32'(k)) % 32'(DMEM_BYTES));
  endfunction

  // Combinational bytewise read, so misaligned accesses need no special case.
  always_comb begin
    rdata = 32'h0000_0000;
    for (int k = 0; k < 4; k++) begin
      rdata[8*k +: 8] = memory[byte_idx(addr, k)];
    end
  end

  // Byte-strobed store; strobe k writes wdata byte k to addr+k.
  always_ff @(posedge clock) begin
    for (int k = 0; k < 4; k++) begin
      if (wstrb[k]) begin
        memory[byte_idx(addr, k)] <= wdata[8*k +: 8];
      end
    end
  end

endmodule

// File: rtl/risc_v_cpu_regs.sv
// Register file: x0 hard-wired to zero, two combinational reads, one clocked write.
module registers_bank (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  input  logic [4:0]  rd_addr,
  input  logic        rd_we,
  input  logic [31:0] rd_data,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data
);

  logic [31:0] registers [0:31];

  // Clear all registers on reset; writes to x0 are dropped.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        registers[i] <= 32'h0000_0000;
      end
    end else if (rd_we && (rd_addr != 5'd0)) begin
      registers[rd_addr] <= rd_data;
    end
  end

  assign rs1_data = (rs1_addr == 5'd0) ? 32'h0000_0000 : registers[rs1_addr];
  assign rs2_data = (rs2_addr == 5'd0) ? 32'h0000_0000 : registers[rs2_addr];

endmodule

// File: rtl/risc_v_cpu.sv
// Single-cycle RV32I core: decode, immediate generation, ALU and branch logic inline;
// PC, register bank and both memories are sub-instances with fixed names.
module risc_v_cpu #(
  parameter int IMEM_BYTES = 1024,
  parameter int DMEM_BYTES = 1024
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] out
);

  import rv32i_pkg::*;

  logic [31:0] pc_s, next_pc_s, instr_s, imm_s;
  logic [31:0] rs1_data_s, rs2_data_s, alu_a_s, alu_b_s, alu_y_s;
  logic [31:0] dmem_rdata_s, load_data_s, wb_s, pc_plus4_s, pc_imm_s;
  logic [6:0]  opcode_s;
  logic [2:0]  f3_s;
  logic [4:0]  rd_s, rs1_s, rs2_s;
  logic [3:0]  wstrb_s;
  logic        use_imm_s, use_pc_s, reg_write_s, is_store_s, is_branch_s;
  logic        is_jal_s, is_jalr_s, br_cond_s;
  imm_sel_t    imm_sel_s;
  alu_op_t     alu_op_s;
  wb_sel_t     wb_sel_s;

  pc_register program_counter (
    .clock   (clock),
    .reset   (reset),
    .next_pc (next_pc_s),
    .pc_addr (pc_s)
  );

  instr_memory #(.IMEM_BYTES(IMEM_BYTES)) uut_instruction (
    .addr  (pc_s),
    .rdata (instr_s)
  );

  registers_bank registers_bank (
    .clock    (clock),
    .reset    (reset),
    .rs1_addr (rs1_s),
    .rs2_addr (rs2_s),
    .rd_addr  (rd_s),
    .rd_we    (reg_write_s),
    .rd_data  (wb_s),
    .rs1_data (rs1_data_s),
    .rs2_data (rs2_data_s)
  );

  data_memory #(.DMEM_BYTES(DMEM_BYTES)) memory (
    .clock (clock),
    .addr  (alu_y_s),
    .wdata (rs2_data_s),
    .wstrb (wstrb_s),
    .rdata (dmem_rdata_s)
  );

  assign opcode_s   = instr_s[6:0];
  assign rd_s       = instr_s[11:7];
  assign f3_s       = instr_s[14:12];
  assign rs1_s      = instr_s[19:15];
  assign rs2_s      = instr_s[24:20];
  assign imm_s      = gen_imm(instr_s, imm_sel_s);
  assign pc_plus4_s = pc_s + 32'd4;
  assign pc_imm_s   = pc_s + imm_s;
  assign alu_a_s    = use_pc_s ? pc_s : rs1_data_s;
  assign alu_b_s    = use_imm_s ? imm_s : rs2_data_s;

  // Main decoder; FENCE/SYSTEM/unknown opcodes keep the all-off defaults (NOP).
  always_comb begin
    imm_sel_s   = IMM_I;
    alu_op_s    = ALU_ADD;
    wb_sel_s    = WB_ALU;
    use_imm_s   = 1'b0;
    use_pc_s    = 1'b0;
    reg_write_s = 1'b0;
    is_store_s  = 1'b0;
    is_branch_s = 1'b0;
    is_jal_s    = 1'b0;
    is_jalr_s   = 1'b0;
    case (opcode_s)
      OPC_LUI: begin
        imm_sel_s = IMM_U; alu_op_s = ALU_PASS_B; use_imm_s = 1'b1; reg_write_s = 1'b1;
      end
      OPC_AUIPC: begin
        imm_sel_s = IMM_U; use_pc_s = 1'b1; use_imm_s = 1'b1; reg_write_s = 1'b1;
      end
      OPC_JAL: begin
        imm_sel_s = IMM_J; is_jal_s = 1'b1; reg_write_s = 1'b1; wb_sel_s = WB_LINK;
      end
      OPC_JALR: begin
        use_imm_s = 1'b1; is_jalr_s = 1'b1; reg_write_s = 1'b1; wb_sel_s = WB_LINK;
      end
      OPC_BRANCH: begin
        imm_sel_s = IMM_B; is_branch_s = 1'b1;
      end
      OPC_LOAD: begin
        use_imm_s = 1'b1; reg_write_s = 1'b1; wb_sel_s = WB_MEM;
      end
      OPC_STORE: begin
        imm_sel_s = IMM_S; use_imm_s = 1'b1; is_store_s = 1'b1;
      end
      OPC_OP_IMM: begin
        use_imm_s = 1'b1; reg_write_s = 1'b1;
        alu_op_s = alu_from_f3(f3_s, (f3_s == F3_SR) && instr_s[30]);
      end
      OPC_OP: begin
        reg_write_s = 1'b1;
        alu_op_s = alu_from_f3(f3_s, instr_s[30]);
      end
      default: begin
        reg_write_s = 1'b0;
      end
    endcase
  end

  // ALU; shift amounts use only the low five bits.
  always_comb begin
    alu_y_s = 32'h0000_0000;
    case (alu_op_s)
      ALU_ADD:    alu_y_s = alu_a_s + alu_b_s;
      ALU_SUB:    alu_y_s = alu_a_s - alu_b_s;
      ALU_SLL:    alu_y_s = alu_a_s << alu_b_s[4:0];
      ALU_SLT:    alu_y_s = {31'd0, $signed(alu_a_s) < $signed(alu_b_s)};
      ALU_SLTU:   alu_y_s = {31'd0, alu_a_s < alu_b_s};
      ALU_XOR:    alu_y_s = alu_a_s ^ alu_b_s;
      ALU_SRL:    alu_y_s = alu_a_s >> alu_b_s[4:0];
      ALU_SRA:    alu_y_s = $signed(alu_a_s) >>> alu_b_s[4:0];
      ALU_OR:     alu_y_s = alu_a_s | alu_b_s;
      ALU_AND:    alu_y_s = alu_a_s & alu_b_s;
      ALU_PASS_B: alu_y_s = alu_b_s;
      default:    alu_y_s = 32'h0000_0000;
    endcase
  end

  // Branch condition evaluation.
  always_comb begin
    br_cond_s = 1'b0;
    case (f3_s)
      F3_BEQ:  br_cond_s = (rs1_data_s == rs2_data_s);
      F3_BNE:  br_cond_s = (rs1_data_s != rs2_data_s);
      F3_BLT:  br_cond_s = ($signed(rs1_data_s) < $signed(rs2_data_s));
      F3_BGE:  br_cond_s = ($signed(rs1_data_s) >= $signed(rs2_data_s));
      F3_BLTU: br_cond_s = (rs1_data_s < rs2_data_s);
      F3_BGEU: br_cond_s = (rs1_data_s >= rs2_data_s);
      default: br_cond_s = 1'b0;
    endcase
  end

  // Next PC selection.
  always_comb begin
    next_pc_s = pc_plus4_s;
    if (is_jal_s) begin
      next_pc_s = pc_imm_s;
    end else if (is_jalr_s) begin
      next_pc_s = alu_y_s & ~32'd1;
    end else if (is_branch_s && br_cond_s) begin
      next_pc_s = pc_imm_s;
    end else begin
      next_pc_s = pc_plus4_s;
    end
  end

  // Load extension.
  always_comb begin
    load_data_s = dmem_rdata_s;
    case (f3_s)
      F3_LB:   load_data_s = {{24{dmem_rdata_s[7]}}, dmem_rdata_s[7:0]};
      F3_LH:   load_data_s = {{16{dmem_rdata_s[15]}}, dmem_rdata_s[15:0]};
      F3_LW:   load_data_s = dmem_rdata_s;
      F3_LBU:  load_data_s = {24'd0, dmem_rdata_s[7:0]};
      F3_LHU:  load_data_s = {16'd0, dmem_rdata_s[15:0]};
      default: load_data_s = dmem_rdata_s;
    endcase
  end

  // Store byte strobes, suppressed while reset is held so memory is untouched.
  always_comb begin
    wstrb_s = 4'b0000;
    if (is_store_s && reset) begin
      case (f3_s)
        F3_SB:   wstrb_s = 4'b0001;
        F3_SH:   wstrb_s = 4'b0011;
        F3_SW:   wstrb_s = 4'b1111;
        default: wstrb_s = 4'b0000;
      endcase
    end else begin
      wstrb_s = 4'b0000;
    end
  end

  // Write-back mux and the observable out value.
  always_comb begin
    wb_s = 32'h0000_0000;
    case (wb_sel_s)
      WB_ALU:  wb_s = alu_y_s;
      WB_MEM:  wb_s = load_data_s;
      WB_LINK: wb_s = pc_plus4_s;
      default: wb_s = 32'h0000_0000;
    endcase
    if (reset && reg_write_s) begin
      out = wb_s;
    end else begin
      out = 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_risc_v_cpu.sv
// Directed table-driven bench for risc_v_cpu: programs are assembled into
// instruction memory, then registers, PC and data memory are checked per edge.
`timescale 1ns/1ps
module tb_risc_v_cpu;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] out;
  int          checks = 0;
  int          errors = 0;

  localparam logic [6:0] OPI = 7'b0010011;
  localparam logic [6:0] OPR = 7'b0110011;
  localparam logic [6:0] OPL = 7'b0000011;

  risc_v_cpu #(.IMEM_BYTES(1024), .DMEM_BYTES(1024)) dut (
    .clock (clock),
    .reset (reset),
    .out   (out)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    int          rd;
    logic [31:0] exp_rd;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[$];
  int   g_start[5];

  function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm[11:0], rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rd, op};
  endfunction

  function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  task automatic add(input logic [31:0] addr, input logic [31:0] instr, input int rd,
                     input logic [31:0] exp_rd, input logic [31:0] exp_pc);
    vec_t v;
    v.addr = addr; v.instr = instr; v.rd = rd; v.exp_rd = exp_rd; v.exp_pc = exp_pc;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic load(input int g);
    for (int i = g_start[g]; i < g_start[g+1]; i++) begin
      for (int k = 0; k < 4; k++) begin
        dut.uut_instruction.memory[int'(vecs[i].addr) + k] = vecs[i].instr[8*k +: 8];
      end
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic start(input int g);
    @(negedge clock);
    reset = 1'b0;
    load(g);
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic run(input int g);
    for (int i = g_start[g]; i < g_start[g+1]; i++) begin
      step();
      check($sformatf("g%0d_i%0d_x%0d", g, i - g_start[g], vecs[i].rd),
            dut.registers_bank.registers[vecs[i].rd], vecs[i].exp_rd);
      check($sformatf("g%0d_i%0d_pc", g, i - g_start[g]), dut.program_counter.pc_addr, vecs[i].exp_pc);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pc"}, dut.program_counter.pc_addr, 32'h0);
    for (int r = 0; r < 32; r++) begin
      check($sformatf("%s_x%0d", tag, r), dut.registers_bank.registers[r], 32'h0);
    end
  endtask

  task automatic check_dmem(input string tag);
    check({tag, "_m8"},    {24'd0, dut.memory.memory[8]},    32'h0000_00FF);
    check({tag, "_m9"},    {24'd0, dut.memory.memory[9]},    32'h0000_0000);
    check({tag, "_m10"},   {24'd0, dut.memory.memory[10]},   32'h0000_00FF);
    check({tag, "_m11"},   {24'd0, dut.memory.memory[11]},   32'h0000_00FF);
    check({tag, "_m1023"}, {24'd0, dut.memory.memory[1023]}, 32'h0000_00FF);
    check({tag, "_m0"},    {24'd0, dut.memory.memory[0]},    32'h0000_00FF);
  endtask

  initial begin
    // Group 0: arithmetic and logic
    g_start[0] = vecs.size();
    add(32'd0,  enc_i(32'd5, 5'd0, 3'd0, 5'd1, OPI),             1,  32'h0000_0005, 32'd4);
    add(32'd4,  enc_i(32'hFFFF_FFFD, 5'd0, 3'd0, 5'd2, OPI),     2,  32'hFFFF_FFFD, 32'd8);
    add(32'd8,  enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3),            3,  32'h0000_0002, 32'd12);
    add(32'd12, enc_r(7'h20, 5'd1, 5'd2, 3'd0, 5'd4),            4,  32'hFFFF_FFF8, 32'd16);
    add(32'd16, enc_r(7'h00, 5'd1, 5'd2, 3'd2, 5'd5),            5,  32'h0000_0001, 32'd20);
    add(32'd20, enc_r(7'h00, 5'd1, 5'd2, 3'd3, 5'd6),            6,  32'h0000_0000, 32'd24);
    add(32'd24, enc_i(32'h0000_0401, 5'd2, 3'd5, 5'd7, OPI),     7,  32'hFFFF_FFFE, 32'd28);
    add(32'd28, enc_r(7'h00, 5'd1, 5'd1, 3'd1, 5'd8),            8,  32'h0000_00A0, 32'd32);
    add(32'd32, enc_r(7'h00, 5'd1, 5'd2, 3'd5, 5'd9),            9,  32'h07FF_FFFF, 32'd36);
    add(32'd36, enc_i(32'hFFFF_FFFF, 5'd1, 3'd3, 5'd10, OPI),    10, 32'h0000_0001, 32'd40);
    add(32'd40, enc_i(32'hFFFF_FFFF, 5'd2, 3'd4, 5'd11, OPI),    11, 32'h0000_0002, 32'd44);
    // Group 1: upper immediates and x0
    g_start[1] = vecs.size();
    add(32'd0, enc_u(20'h12345, 5'd1, 7'b0110111),               1,  32'h1234_5000, 32'd4);
    add(32'd4, enc_u(20'h00001, 5'd2, 7'b0010111),               2,  32'h0000_1004, 32'd8);
    add(32'd8, enc_i(32'd7, 5'd0, 3'd0, 5'd0, OPI),              0,  32'h0000_0000, 32'd12);
    // Group 2: branches and jumps
    g_start[2] = vecs.size();
    add(32'd0,  enc_b(32'd8, 5'd0, 5'd0, 3'd0),                  0,  32'h0000_0000, 32'd8);
    add(32'd8,  enc_j(32'd12, 5'd1),                             1,  32'h0000_000C, 32'd20);
    add(32'd20, enc_i(32'd1, 5'd1, 3'd0, 5'd2, 7'b1100111),      2,  32'h0000_0018, 32'd12);
    add(32'd12, enc_b(32'd16, 5'd0, 5'd0, 3'd1),                 0,  32'h0000_0000, 32'd16);
    add(32'd16, enc_b(32'hFFFF_FFF0, 5'd2, 5'd1, 3'd6),          1,  32'h0000_000C, 32'd0);
    // Group 3: loads and stores, including a wrapping halfword
    g_start[3] = vecs.size();
    add(32'd0,  enc_i(32'hFFFF_FFFF, 5'd0, 3'd0, 5'd1, OPI),     1,  32'hFFFF_FFFF, 32'd4);
    add(32'd4,  enc_s(32'd8, 5'd1, 5'd0, 3'd2),                  0,  32'h0000_0000, 32'd8);
    add(32'd8,  enc_s(32'd9, 5'd0, 5'd0, 3'd0),                  0,  32'h0000_0000, 32'd12);
    add(32'd12, enc_i(32'd8, 5'd0, 3'd2, 5'd2, OPL),             2,  32'hFFFF_00FF, 32'd16);
    add(32'd16, enc_i(32'd8, 5'd0, 3'd4, 5'd3, OPL),             3,  32'h0000_00FF, 32'd20);
    add(32'd20, enc_i(32'd8, 5'd0, 3'd1, 5'd4, OPL),             4,  32'h0000_00FF, 32'd24);
    add(32'd24, enc_i(32'd10, 5'd0, 3'd0, 5'd5, OPL),            5,  32'hFFFF_FFFF, 32'd28);
    add(32'd28, enc_s(32'd1023, 5'd1, 5'd0, 3'd1),               0,  32'h0000_0000, 32'd32);
    add(32'd32, enc_i(32'd1023, 5'd0, 3'd5, 5'd6, OPL),          6,  32'h0000_FFFF, 32'd36);
    g_start[4] = vecs.size();

    // Reset with program preloaded: state cleared before any edge, out forced to 0
    #2 reset = 1'b0;
    load(0);
    #1;
    check_all_zero("reset");
    check("reset_out", out, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("out_first_addi", out, 32'h0000_0005);
    run(0);

    start(1); run(1);
    start(2); run(2);
    start(3); run(3);
    check_dmem("ls");

    // Async reset between edges after three instructions
    start(3);
    step(); step(); step();
    #2 reset = 1'b0;
    #1;
    check_all_zero("midrst");
    check_dmem("midrst");
    @(negedge clock);
    reset = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
